fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the pipelined MIPS datapath. Owns the PC, issues word reads to the instruction memory/cache with an ihit handshake, and presents each fetched instruction with its PC+4 to the decode stage, where its opcode/funct fields drive the control unit. Supports pipeline stall, taken-branch/jump redirect from EX (including squash of an in-flight fetch), and sticky halt.

---
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage and IF/ID pipeline register of the pipelined MIPS
// datapath. It owns the PC and issues word reads to instruction memory with
// an ihit handshake. Each fetched word is presented to decode together with
// its PC+4. The stage also handles hazard stalls, taken-branch/jump redirects
// from EX (squashing a fetch that is still in flight), and a sticky halt.
//
// Ports:
//   CLK          clock; all state updates on the rising edge
//   nRST         asynchronous active-low reset
//   iREN         instruction read request (low only once halted)
//   imemaddr     instruction address, always equal to pc
//   ihit         memory returns imemload for imemaddr this cycle
//   imemload     instruction word from memory
//   stall        hazard unit request to hold IF/ID and pc
//   redirect     EX resolved a taken branch/jump/JR
//   redirect_pc  redirect target (low two bits ignored)
//   halt_in      decode sees HALT in a valid IF/ID entry
//   instr        IF/ID instruction
//   npc          IF/ID PC+4
//   valid        IF/ID holds a real instruction
//   halted       processor halted (sticky until reset)

module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt_in,
   output logic [31:0] instr,
   output logic [31:0] npc,
   output logic        valid,
   output logic        halted
);

   localparam logic [1:0] FETCH  = 2'd0;
   localparam logic [1:0] SQUASH = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]  state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] target, target_n;
   logic [31:0] instr_n, npc_n;
   logic        valid_n;
   logic [31:0] aligned_pc;
   logic [31:0] pc_plus4;

   assign aligned_pc = {redirect_pc[31:2], 2'b00};
   assign pc_plus4   = pc + 32'd4;

   assign imemaddr = pc;
   assign iREN     = (state == FETCH) || (state == SQUASH);
   assign halted   = (state == HALTED);

   // Next-state logic. In FETCH a redirect outranks halt and stall, because
   // both of those refer to an instruction on the wrong path. A redirect that
   // arrives without ihit cannot move pc yet, since the memory is still
   // answering the old address. The target is parked and the SQUASH state
   // throws away that answer when it finally comes back.
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      target_n = target;
      instr_n  = instr;
      npc_n    = npc;
      valid_n  = valid;
      case (state)
         FETCH: begin
            if (redirect) begin
               valid_n = 1'b0;
               if (ihit) begin
                  pc_n = aligned_pc;
               end else begin
                  target_n = aligned_pc;
                  state_n  = SQUASH;
               end
            end else if (halt_in) begin
               valid_n = 1'b0;
               state_n = HALTED;
            end else if (stall) begin
               valid_n = valid;
            end else if (ihit) begin
               instr_n = imemload;
               npc_n   = pc_plus4;
               valid_n = 1'b1;
               pc_n    = pc_plus4;
            end else begin
               valid_n = 1'b0;
            end
         end
         SQUASH: begin
            valid_n = 1'b0;
            if (redirect) begin
               target_n = aligned_pc;
               if (ihit) begin
                  pc_n    = aligned_pc;
                  state_n = FETCH;
               end
            end else if (ihit) begin
               pc_n    = target;
               state_n = FETCH;
            end
         end
         HALTED: begin
            valid_n = 1'b0;
         end
         default: begin
            valid_n = 1'b0;
            state_n = FETCH;
         end
      endcase
   end

   // State registers. Reset is asynchronous, so a pending squash target is
   // dropped immediately and fetching restarts from PC_INIT.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= FETCH;
         pc     <= PC_INIT;
         target <= 32'd0;
         instr  <= 32'd0;
         npc    <= 32'd0;
         valid  <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         target <= target_n;
         instr  <= instr_n;
         npc    <= npc_n;
         valid  <= valid_n;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage. The memory returns a word derived
// from its address. Whenever a task drives an accepted fetch, it pushes the
// expected IF/ID contents into a scoreboard queue. The entry is popped and
// compared on the cycle after the load edge.

module tb_fetch_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        iren;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt_in;
   logic [31:0] instr;
   logic [31:0] npc;
   logic        valid;
   logic        halted;

   exp_t sb[$];
   int   total;
   int   bad;

   fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
      .CLK(clk),
      .nRST(rst_n),
      .iREN(iren),
      .imemaddr(imemaddr),
      .ihit(ihit),
      .imemload(imemload),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .halt_in(halt_in),
      .instr(instr),
      .npc(npc),
      .valid(valid),
      .halted(halted)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
   endfunction

   // The memory model always answers with the word for the current address.
   always_comb imemload = word_of(imemaddr);

   // Queue the IF/ID contents expected from accepting a fetch at address a.
   task automatic push_fetch(input logic [31:0] a);
      exp_t e;
      e.instr = word_of(a);
      e.npc   = a + 32'd4;
      sb.push_back(e);
   endtask

   // Advance one clock and sample 1 unit after the edge. A pending scoreboard
   // entry must be the IF/ID contents just loaded.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (valid !== 1'b1 || instr !== e.instr || npc !== e.npc) begin
            bad++;
            $display("[TB] FAIL ifid_load: got v=%b instr=%h npc=%h want v=1 instr=%h npc=%h",
                     valid, instr, npc, e.instr, e.npc);
         end
      end
   endtask

   task automatic clear_inputs();
      ihit        = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      halt_in     = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (imemaddr !== 32'h0 || valid !== 1'b0 || halted !== 1'b0 || iren !== 1'b1 ||
          instr !== 32'h0 || npc !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_state: got addr=%h v=%b h=%b ren=%b instr=%h npc=%h want 0/0/0/1/0/0",
                  imemaddr, valid, halted, iren, instr, npc);
      end
   endtask

   // Zero-wait fetches of 0 and 4, then three wait states at 8.
   task automatic test_wait_states();
      ihit = 1'b1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (imemaddr !== 32'(i * 4)) begin
            bad++;
            $display("[TB] FAIL seq_addr: got %h want %h", imemaddr, 32'(i * 4));
         end
         push_fetch(32'(i * 4));
         tick();
      end
      ihit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (imemaddr !== 32'h8 || valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wait_hold: got addr=%h v=%b want addr=00000008 v=0", imemaddr, valid);
         end
      end
      ihit = 1'b1;
      push_fetch(32'h8);
      tick();
      push_fetch(32'hC);
      tick();
      total++;
      if (imemaddr !== 32'h10) begin
         bad++;
         $display("[TB] FAIL seq_after_wait: got %h want 00000010", imemaddr);
      end
   endtask

   task automatic test_stall();
      push_fetch(32'h10);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (instr !== word_of(32'h10) || npc !== 32'h14 || valid !== 1'b1 || imemaddr !== 32'h14) begin
            bad++;
            $display("[TB] FAIL stall_hold: got instr=%h npc=%h v=%b addr=%h want %h 00000014 1 00000014",
                     instr, npc, valid, imemaddr, word_of(32'h10));
         end
      end
      stall = 1'b0;
      push_fetch(32'h14);
      tick();
      push_fetch(32'h18);
      tick();
   endtask

   task automatic test_redirect_squash();
      redirect    = 1'b1;
      redirect_pc = 32'h10;
      ihit        = 1'b1;
      tick();
      total++;
      if (imemaddr !== 32'h10 || valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL redirect_hit: got addr=%h v=%b want 00000010 0", imemaddr, valid);
      end
      redirect_pc = 32'h40;
      ihit        = 1'b0;
      tick();
      redirect = 1'b0;
      total++;
      if (imemaddr !== 32'h10 || valid !== 1'b0 || iren !== 1'b1) begin
         bad++;
         $display("[TB] FAIL squash_enter: got addr=%h v=%b ren=%b want 00000010 0 1", imemaddr, valid, iren);
      end
      tick();
      total++;
      if (imemaddr !== 32'h10 || valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL squash_hold: got addr=%h v=%b want 00000010 0", imemaddr, valid);
      end
      ihit = 1'b1;
      tick();
      total++;
      if (imemaddr !== 32'h40 || valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL squash_discard: got addr=%h v=%b want 00000040 0", imemaddr, valid);
      end
      push_fetch(32'h40);
      tick();
      // A second redirect during SQUASH replaces the parked target, and
      // stall/halt are ignored there.
      redirect    = 1'b1;
      redirect_pc = 32'h60;
      ihit        = 1'b0;
      tick();
      redirect_pc = 32'h80;
      tick();
      total++;
      if (imemaddr !== 32'h44) begin
         bad++;
         $display("[TB] FAIL squash2_hold: got %h want 00000044", imemaddr);
      end
      redirect = 1'b0;
      ihit     = 1'b1;
      stall    = 1'b1;
      halt_in  = 1'b1;
      tick();
      stall   = 1'b0;
      halt_in = 1'b0;
      total++;
      if (imemaddr !== 32'h80 || halted !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL squash_newest: got addr=%h h=%b v=%b want 00000080 0 0", imemaddr, halted, valid);
      end
      push_fetch(32'h80);
      tick();
   endtask

   task automatic test_halt();
      redirect    = 1'b1;
      redirect_pc = 32'hA0;
      halt_in     = 1'b1;
      ihit        = 1'b1;
      tick();
      redirect = 1'b0;
      halt_in  = 1'b0;
      total++;
      if (imemaddr !== 32'hA0 || halted !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL redirect_beats_halt: got addr=%h h=%b v=%b want 000000a0 0 0", imemaddr, halted, valid);
      end
      push_fetch(32'hA0);
      tick();
      halt_in = 1'b1;
      tick();
      total++;
      if (halted !== 1'b1 || iren !== 1'b0 || valid !== 1'b0 || imemaddr !== 32'hA4) begin
         bad++;
         $display("[TB] FAIL halt_enter: got h=%b ren=%b v=%b addr=%h want 1 0 0 000000a4", halted, iren, valid, imemaddr);
      end
      halt_in     = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (halted !== 1'b1 || valid !== 1'b0 || imemaddr !== 32'hA4) begin
            bad++;
            $display("[TB] FAIL halt_sticky: got h=%b v=%b addr=%h want 1 0 000000a4", halted, valid, imemaddr);
         end
      end
   endtask

   task automatic test_wrap_align();
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      ihit        = 1'b1;
      tick();
      redirect = 1'b0;
      total++;
      if (imemaddr !== 32'hFFFF_FFFC) begin
         bad++;
         $display("[TB] FAIL align_top: got %h want fffffffc", imemaddr);
      end
      push_fetch(32'hFFFF_FFFC);
      tick();
      total++;
      if (imemaddr !== 32'h0) begin
         bad++;
         $display("[TB] FAIL wrap_addr: got %h want 00000000", imemaddr);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h43;
      tick();
      redirect = 1'b0;
      total++;
      if (imemaddr !== 32'h40) begin
         bad++;
         $display("[TB] FAIL align_43: got %h want 00000040", imemaddr);
      end
      push_fetch(32'h40);
      tick();
   endtask

   task automatic test_reset_mid_squash();
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      ihit        = 1'b0;
      tick();
      redirect = 1'b0;
      tick();
      total++;
      if (imemaddr !== 32'h44) begin
         bad++;
         $display("[TB] FAIL squash3_hold: got %h want 00000044", imemaddr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (imemaddr !== 32'h0 || valid !== 1'b0 || iren !== 1'b1 || halted !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset: got addr=%h v=%b ren=%b h=%b want 0 0 1 0", imemaddr, valid, iren, halted);
      end
      rst_n = 1'b1;
      ihit  = 1'b1;
      push_fetch(32'h0);
      tick();
      total++;
      if (imemaddr !== 32'h4) begin
         bad++;
         $display("[TB] FAIL target_lost: got %h want 00000004", imemaddr);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_wait_states();
      test_stall();
      test_redirect_squash();
      test_halt();
      test_wrap_align();
      test_reset_mid_squash();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
